// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha core driver.
// Holds the controller state encoding, the byte counts of each load/read
// phase and the width of the shared byte counter.
package chacha_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_KEY,
    LD_NNC,
    LD_CTR,
    WAIT_RDY,
    READ,
    NEXT,
    FIN
  } state_t;

  localparam int unsigned KEY_BYTES = 32;
  localparam int unsigned NNC_BYTES = 12;
  localparam int unsigned CTR_BYTES = 4;
  localparam int unsigned BLK_BYTES = 64;

  // One counter covers every phase; the largest phase is 64 bytes.
  localparam int unsigned CNT_W = 6;

  // Counter value on the final byte of a phase of n bytes.
  function automatic logic [CNT_W-1:0] last_idx(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/chacha_driver.sv
// ChaCha core driver: loads key, nonce and block counter from an upstream
// byte stream into the core, then streams 64-byte keystream blocks out,
// rewriting the incremented block counter between blocks.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, nblk       run request (IDLE only) and block count (0 means 1)
//   s_valid/s_ready/s_data   upstream 48 load bytes (key, nonce, counter)
//   m_valid/m_ready/m_data   downstream keystream bytes
//   wr_key/wr_nnc/wr_ctr/rd_blk  core write/read strobes
//   core_data_in/core_data_out   core byte buses
//   blk_ready         core has a block available
//   busy, done        run active / one-cycle end-of-run pulse
module chacha_driver #(
  parameter int NBLK_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NBLK_W-1:0] nblk,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              wr_key,
  output logic              wr_nnc,
  output logic              wr_ctr,
  output logic              rd_blk,
  output logic [7:0]        core_data_in,
  input  logic [7:0]        core_data_out,
  input  logic              blk_ready,
  output logic              busy,
  output logic              done
);
  import chacha_pkg::*;

  state_t            state;
  logic [CNT_W-1:0]  byte_cnt;
  logic [NBLK_W-1:0] blk_left;
  logic [31:0]       ctr;
  // Set once the first block is done: LD_CTR then replays ctr itself
  // instead of taking bytes from the upstream stream.
  logic              ctr_reload;
  logic [7:0]        ctr_byte;

  assign ctr_byte = ctr[{byte_cnt[1:0], 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      blk_left   <= '0;
      ctr        <= '0;
      ctr_reload <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LD_KEY;
            byte_cnt   <= '0;
            ctr_reload <= 1'b0;
            blk_left   <= (nblk == '0) ? NBLK_W'(1) : nblk;
          end
        end
        LD_KEY: begin
          if (s_valid) begin
            if (byte_cnt == last_idx(KEY_BYTES)) begin
              byte_cnt <= '0;
              state    <= LD_NNC;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        LD_NNC: begin
          if (s_valid) begin
            if (byte_cnt == last_idx(NNC_BYTES)) begin
              byte_cnt <= '0;
              state    <= LD_CTR;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        LD_CTR: begin
          if (ctr_reload || s_valid) begin
            if (!ctr_reload) begin
              ctr[{byte_cnt[1:0], 3'b000} +: 8] <= s_data;
            end
            if (byte_cnt == last_idx(CTR_BYTES)) begin
              byte_cnt <= '0;
              state    <= WAIT_RDY;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        WAIT_RDY: begin
          if (blk_ready) begin
            state <= READ;
          end
        end
        READ: begin
          if (m_ready) begin
            if (byte_cnt == last_idx(BLK_BYTES)) begin
              byte_cnt <= '0;
              blk_left <= blk_left - NBLK_W'(1);
              state    <= (blk_left == NBLK_W'(1)) ? FIN : NEXT;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        NEXT: begin
          ctr        <= ctr + 32'd1;
          ctr_reload <= 1'b1;
          state      <= LD_CTR;
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the state register; everything is forced to
  // zero while rst_n is low so nothing leaks before the reset edge lands.
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    m_data       = '0;
    wr_key       = 1'b0;
    wr_nnc       = 1'b0;
    wr_ctr       = 1'b0;
    rd_blk       = 1'b0;
    core_data_in = '0;
    if (rst_n) begin
      busy = (state != IDLE);
      done = (state == FIN);
      case (state)
        LD_KEY: begin
          s_ready      = 1'b1;
          wr_key       = s_valid;
          core_data_in = s_data;
        end
        LD_NNC: begin
          s_ready      = 1'b1;
          wr_nnc       = s_valid;
          core_data_in = s_data;
        end
        LD_CTR: begin
          if (ctr_reload) begin
            wr_ctr       = 1'b1;
            core_data_in = ctr_byte;
          end else begin
            s_ready      = 1'b1;
            wr_ctr       = s_valid;
            core_data_in = s_data;
          end
        end
        READ: begin
          m_valid = 1'b1;
          rd_blk  = m_ready;
          m_data  = core_data_out;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_driver.sv
// Self-checking bench for chacha_driver: randomized upstream/downstream
// handshakes against a reference built from the byte-stream rules
// (load bytes in order, counter rewritten as initial+block index,
// 64 keystream bytes per block read in core address order).
module tb_chacha_driver;
  localparam int NBLK_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [NBLK_W-1:0] nblk = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [7:0]        s_data = 8'hA5;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [7:0]        m_data;
  logic              wr_key, wr_nnc, wr_ctr, rd_blk;
  logic [7:0]        core_data_in;
  logic [7:0]        core_data_out;
  logic              blk_ready = 1'b0;
  logic              busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  chacha_driver #(.NBLK_W(NBLK_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nblk(nblk),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .wr_key(wr_key), .wr_nnc(wr_nnc), .wr_ctr(wr_ctr), .rd_blk(rd_blk),
    .core_data_in(core_data_in), .core_data_out(core_data_out),
    .blk_ready(blk_ready), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Core model: keystream byte is a fixed function of the read address,
  // which advances on every rd_blk.
  function automatic logic [7:0] ks_byte(input int unsigned a);
    return 8'((a * 37 + 11) ^ (a >> 8));
  endfunction

  int unsigned rd_total = 0;
  assign core_data_out = ks_byte(rd_total);
  always @(posedge clk) if (rd_blk) rd_total <= rd_total + 1;

  // Monitor
  logic [7:0]  key_q[$], nnc_q[$], ctr_q[$], ks_q[$];
  int          done_cnt, rd_noready, multi_strobe, idle_active, ks_bad;
  int unsigned ks_base;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_key) key_q.push_back(core_data_in);
      if (wr_nnc) nnc_q.push_back(core_data_in);
      if (wr_ctr) ctr_q.push_back(core_data_in);
      if (m_valid && m_ready) begin
        if (m_data != ks_byte(ks_base + ks_q.size())) ks_bad++;
        ks_q.push_back(m_data);
      end
      if (rd_blk && !m_ready) rd_noready++;
      if (int'(wr_key) + int'(wr_nnc) + int'(wr_ctr) + int'(rd_blk) > 1) multi_strobe++;
      if (!busy && (s_ready || m_valid || wr_key || wr_nnc || wr_ctr || rd_blk || done))
        idle_active++;
      if (done) done_cnt++;
    end
  end

  task automatic clear_mon();
    key_q.delete(); nnc_q.delete(); ctr_q.delete(); ks_q.delete();
    done_cnt = 0; rd_noready = 0; multi_strobe = 0; idle_active = 0; ks_bad = 0;
    ks_base = rd_total;
  endtask

  logic [7:0] ld [48];

  task automatic prepare_load(input logic [31:0] c0);
    for (int i = 0; i < 44; i++) ld[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) ld[44 + i] = c0[8*i +: 8];
  endtask

  // Present the 48 load bytes; start_at >= 0 raises start while that byte
  // index is being offered.
  task automatic feed(input int pv, input int start_at);
    int idx = 0;
    int cyc = 0;
    bit hs;
    while (idx < 48 && cyc < 4000) begin
      s_valid = ($urandom_range(99) < pv);
      s_data  = ld[idx];
      start   = (start_at >= 0 && idx == start_at);
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    if (idx < 48) check("feed_timeout", idx, 48);
  endtask

  task automatic wait_done(input int pr, input int pb);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      m_ready   = ($urandom_range(99) < pr);
      blk_ready = ($urandom_range(99) < pb);
      @(posedge clk); #1;
      cyc++;
    end
    m_ready   = 1'b0;
    blk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int nb);
    nblk  = NBLK_W'(nb);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_job(input int n, input logic [31:0] c0);
    int mism = 0;
    logic [31:0] v;
    check("key_cnt", key_q.size(), 32);
    check("nnc_cnt", nnc_q.size(), 12);
    check("ctr_cnt", ctr_q.size(), 4 * n);
    check("ks_cnt", ks_q.size(), 64 * n);
    check("done_cnt", done_cnt, 1);
    for (int i = 0; i < 32 && i < key_q.size(); i++) if (key_q[i] != ld[i]) mism++;
    for (int i = 0; i < 12 && i < nnc_q.size(); i++) if (nnc_q[i] != ld[32 + i]) mism++;
    for (int b = 0; b < n; b++) begin
      v = c0 + 32'(b);
      for (int j = 0; j < 4; j++)
        if (4*b + j < ctr_q.size() && ctr_q[4*b + j] != v[8*j +: 8]) mism++;
    end
    check("load_bytes", mism, 0);
    check("ks_data", ks_bad, 0);
    check("rd_noready", rd_noready, 0);
    check("one_hot", multi_strobe, 0);
    check("idle_quiet", idle_active, 0);
  endtask

  task automatic run_job(input int nb, input logic [31:0] c0, input int pv,
                         input int pr, input int pb);
    int n = (nb == 0) ? 1 : nb;
    prepare_load(c0);
    clear_mon();
    pulse_start(nb);
    fork
      feed(pv, -1);
      wait_done(pr, pb);
    join
    check_job(n, c0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int mv_early;
    logic [31:0] c0;

    // Reset: outputs must be quiet during and after reset.
    rst_n = 1'b0;
    clear_mon();
    @(negedge clk);
    check("rst_during", {busy, done, s_ready, m_valid, wr_key, wr_nnc, wr_ctr,
                         rd_blk, core_data_in, m_data}, 0);
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check("rst_after", {busy, done, s_ready, m_valid, wr_key, wr_nnc, wr_ctr,
                        rd_blk, core_data_in, m_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;

    // Single block, no backpressure.
    run_job(1, $urandom, 100, 100, 100);

    // Multi-block with counter wrap.
    run_job(3, 32'hFFFF_FFFF, 100, 100, 100);
    check("wrap_ctr1", {ctr_q[7], ctr_q[6], ctr_q[5], ctr_q[4]}, 0);
    check("wrap_ctr2", {ctr_q[11], ctr_q[10], ctr_q[9], ctr_q[8]}, 1);

    // nblk = 0 behaves as one block.
    run_job(0, $urandom, 100, 100, 100);

    // Randomized backpressure runs.
    for (int r = 0; r < 6; r++) begin
      c0 = (r % 2 == 0) ? 32'hFFFF_FFFE : 32'($urandom);
      run_job($urandom_range(4), c0, 50, 50, 60);
    end

    // Reset in the middle of READ after 20 keystream bytes.
    prepare_load($urandom);
    clear_mon();
    m_ready   = 1'b1;
    blk_ready = 1'b1;
    pulse_start(2);
    feed(100, -1);
    cyc = 0;
    while (ks_q.size() < 20 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reach20", ks_q.size(), 20);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_quiet", {busy, m_valid, rd_blk, done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", {busy, m_valid, rd_blk}, 0);
    m_ready   = 1'b0;
    blk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    run_job(1, $urandom, 100, 100, 100);

    // start during LD_NNC ignored; blk_ready held low in WAIT_RDY.
    c0 = $urandom;
    prepare_load(c0);
    clear_mon();
    m_ready   = 1'b1;
    blk_ready = 1'b0;
    pulse_start(1);
    feed(100, 36);
    mv_early = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_valid) mv_early++;
      @(posedge clk); #1;
    end
    check("wait_no_mvalid", mv_early, 0);
    check("wait_busy", busy, 1);
    blk_ready = 1'b1;
    @(negedge clk);
    check("mvalid_same", m_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mvalid_next", m_valid, 1);
    @(posedge clk); #1;
    wait_done(100, 100);
    check_job(1, c0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chacha_driver.md
CHACHA_DRIVER -- requirements
Module: chacha_driver

Interface
REQ-001 SHALL have parameter NBLK_W, default 8, width of the block-count input.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a keystream run; sampled only in IDLE.
REQ-005 SHALL have port nblk  input  NBLK_W  number of 64-byte blocks to produce; captured on accepted start.
REQ-006 SHALL have ports s_valid/s_ready/s_data  input/output/input  1/1/8  upstream stream of 48 load bytes: 32 key, 12 nonce, 4 counter (little-endian).
REQ-007 SHALL have ports m_valid/m_ready/m_data  output/input/output  1/1/8  downstream keystream byte stream.
REQ-008 SHALL have ports wr_key, wr_nnc, wr_ctr, rd_blk  output  1 each  core write/read strobes.
REQ-009 SHALL have ports core_data_in  output  8  and core_data_out  input  8  core byte buses; blk_ready  input  1  core block-available flag.
REQ-010 SHALL have ports busy  output  1  high outside IDLE; done  output  1  one-cycle pulse at run end.

Function
REQ-011 SHALL implement states IDLE, LD_KEY, LD_NNC, LD_CTR, WAIT_RDY, READ, NEXT, FIN.
REQ-012 IDLE -> LD_KEY on start; the byte counter SHALL clear and nblk SHALL be captured, with nblk=0 treated as 1.
REQ-013 In LD_KEY/LD_NNC/LD_CTR, s_ready SHALL equal 1 and the matching wr_* strobe SHALL equal s_valid; core_data_in SHALL equal s_data combinationally.
REQ-014 A byte SHALL transfer only on a cycle with s_valid=1; s_valid=0 SHALL hold the byte counter and drive all wr_* low.
REQ-015 LD_KEY SHALL last exactly 32 transfers, then LD_NNC 12 transfers, then LD_CTR 4 transfers, then WAIT_RDY.
REQ-016 During the first LD_CTR pass, the 4 counter bytes SHALL be captured into an internal 32-bit ctr, byte 0 = bits 7:0.
REQ-017 WAIT_RDY SHALL last at least one cycle and SHALL exit to READ on the first cycle blk_ready=1.
REQ-018 In READ, m_valid SHALL be 1, m_data SHALL equal core_data_out combinationally, and rd_blk SHALL equal m_ready.
REQ-019 A keystream byte SHALL transfer only when m_ready=1; m_ready=0 SHALL hold rd_blk low so the core address does not advance.
REQ-020 READ SHALL end after exactly 64 transfers, then decrement the remaining-block count.
REQ-021 If blocks remain, READ SHALL go to NEXT; otherwise it SHALL go to FIN.
REQ-022 NEXT SHALL last one cycle, set ctr <= ctr+1 mod 2^32 (0xFFFFFFFF wraps to 0, no flag), and go to LD_CTR.
REQ-023 LD_CTR re-entered from NEXT SHALL drive wr_ctr=1 for 4 consecutive cycles with core_data_in = ctr bytes LSB first, ignoring the s_* stream, with s_ready=0.
REQ-024 FIN SHALL pulse done=1 for one cycle and return to IDLE.
REQ-025 start outside IDLE SHALL be ignored, with no effect on the run.
REQ-026 Outside its owning state, each strobe, s_ready and m_valid SHALL be 0; wr_key, wr_nnc, wr_ctr and rd_blk SHALL never be high simultaneously.

Reset
REQ-027 On rst_n=0 at a clock edge, the block SHALL enter IDLE and clear byte counter, block count and ctr.
REQ-028 During and after reset, all outputs SHALL be 0 (busy, done, strobes, s_ready, m_valid, core_data_in, m_data=0).
REQ-029 Reset mid-run SHALL abort immediately with no done pulse; a fresh start SHALL re-load all 48 bytes.

Structure
REQ-030 chacha_pkg SHALL hold the state enum and constants KEY_BYTES=32, NNC_BYTES=12, CTR_BYTES=4, BLK_BYTES=64.
REQ-031 The block SHALL be a single module with no sub-module; one 6-bit shared byte counter SHALL serve all phases.

Verification
REQ-032 Reset sequence: rst_n low 2 cycles -> all outputs 0, busy=0.
REQ-033 Single block: start, nblk=1, 48 bytes streamed with s_valid always 1 -> wr_key high 32 cycles, wr_nnc 12, wr_ctr 4, then 64 m transfers, and done exactly once.
REQ-034 Multi-block wrap: nblk=3, counter bytes FF FF FF FF -> rewritten counter bytes are 00 00 00 00, then 01 00 00 00; 192 keystream bytes, done once.
REQ-035 Backpressure: random s_valid and m_ready at 50% -> strobe counts stay exactly 32/12/4/64, and rd_blk is never high while m_ready=0.
REQ-036 Reset mid-READ after 20 bytes -> IDLE next cycle, no done; a new start reloads all 48 bytes.
REQ-037 start during LD_NNC and blk_ready held low 10 cycles -> start ignored, and READ begins on the cycle after blk_ready rises.
